// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only register bank: 16-bit frames {wr, addr[6:0], data[7:0]}
// are oversampled in the clk domain and committed to a register on nCS rise.
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ncs_hist_q, ncs_hist_d;
    logic [15:0]            shift_q, shift_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [1:0]             state_q, state_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];
    logic                   wr_strobe_q, wr_strobe_d;
    logic [6:0]             wr_addr_q, wr_addr_d;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_rise, ncs_fall, frame_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q;

    assign frame_ok = shift_q[15] && (cnt_q == 5'd16) &&
                      ({1'b0, shift_q[14:8]} < NUM_REGS_W);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        sclk_hist_d = sclk_s;
        ncs_hist_d  = ncs_s;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ncs_fall) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    // Register and strobe update on the same edge the FSM enters
                    // COMMIT, which keeps latency at SYNC_STAGES+1 edges.
                    if (frame_ok) begin
                        state_d     = ST_COMMIT;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = shift_q[14:8];
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
                        end
                    end
                end else if (ncs_fall) begin
                    cnt_d = '0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                end
            end
            ST_COMMIT: begin
                cnt_d   = '0;
                state_d = ncs_fall ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_hist_q <= sclk_hist_d;
            ncs_hist_q  <= ncs_hist_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Output slots beyond NUM_REGS read as zero.
    logic [4:0][7:0] out_regs;
    for (genvar g = 0; g < 5; g++) begin : g_out
        if (g < NUM_REGS) begin : g_on
            assign out_regs[g] = regs_q[g];
        end else begin : g_off
            assign out_regs[g] = '0;
        end
    end

    assign en_reg_out_7_0  = out_regs[0];
    assign en_reg_out_15_8 = out_regs[1];
    assign en_reg_pwm_7_0  = out_regs[2];
    assign en_reg_pwm_15_8 = out_regs[3];
    assign pwm_duty_cycle  = out_regs[4];
    assign wr_strobe       = wr_strobe_q;
    assign wr_addr         = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: table of frames plus reset-mid-frame and minimum
// timing sequences; committed writes are tracked in a scoreboard queue.
module tb_spi_reg_bank;

    logic       clk = 1'b0;
    logic       rst, sclk, copi, ncs;
    logic [7:0] r0, r1, r2, r3, r4;
    logic       wr_strobe;
    logic [6:0] wr_addr;

    spi_reg_bank #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        int         t;
    } exp_t;

    typedef struct {
        logic [16:0] bits;
        int          n;
        logic        wr;
    } vec_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    vec_t       vt[12];
    logic [7:0] exp_regs[5];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         npush = 0;
    int         nstrobe = 0;
    int         half = 5;
    int         ph = 1;
    int         lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_reg(input logic [6:0] a);
        case (a)
            7'd0:    return r0;
            7'd1:    return r1;
            7'd2:    return r2;
            7'd3:    return r3;
            7'd4:    return r4;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int a = 0; a < 5; a++)
            chk($sformatf("%s_reg%0d", tag, a), 32'(get_reg(7'(a))), 32'(exp_regs[a]));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #(ph);
    endtask

    task automatic cs_low();
        ncs = 1'b0;
        tick(half);
    endtask

    task automatic send_bits(input logic [16:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = w[i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_high(input logic wr, input logic [15:0] f, input logic settle);
        tick(half);
        ncs = 1'b1;
        if (wr) begin
            npush++;
            sbq.push_back('{f[14:8], f[7:0], cyc});
            exp_regs[int'(f[14:8])] = f[7:0];
        end
        tick(half);
        if (settle) begin
            tick(6);
            check_regs($sformatf("frame_%04h", f));
        end
    endtask

    // Every strobe must match the oldest expected write, within 3..4 edges of nCS rise.
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            nstrobe++;
            if (sbq.size() == 0) begin
                chk("unexpected_strobe", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sbq.pop_front();
                lat   = cyc - mon_e.t;
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("strobe_data", 32'(get_reg(mon_e.addr)), 32'(mon_e.data));
                chk("latency_3_or_4", 32'((lat == 3) || (lat == 4)), 32'd1);
            end
        end
    end

    initial begin
        vt[0]  = '{17'h084A5, 16, 1'b1};
        vt[1]  = '{17'h080FF, 16, 1'b1};
        vt[2]  = '{17'h08101, 16, 1'b1};
        vt[3]  = '{17'h08280, 16, 1'b1};
        vt[4]  = '{17'h083F0, 16, 1'b1};
        vt[5]  = '{17'h08433, 16, 1'b1};
        vt[6]  = '{17'h00455, 16, 1'b0};
        vt[7]  = '{17'h08555, 16, 1'b0};
        vt[8]  = '{17'h0FF55, 16, 1'b0};
        vt[9]  = '{17'h00255, 15, 1'b0};  // leaves 0x8255 in the shifter, only 15 bits
        vt[10] = '{17'h18255, 17, 1'b0};  // last 16 bits form a valid write
        vt[11] = '{17'h08433, 16, 1'b1};  // same value again still strobes

        for (int a = 0; a < 5; a++) exp_regs[a] = 8'h00;
        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_regs("reset");
        chk("reset_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        tick(4);

        for (int i = 0; i < 12; i++) begin
            cs_low();
            send_bits(vt[i].bits, vt[i].n);
            cs_high(vt[i].wr, vt[i].bits[15:0], 1'b1);
        end

        // Reset after 8 bits with nCS still low: the tail of the frame is ignored.
        cs_low();
        send_bits(17'h00082, 8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int a = 0; a < 5; a++) exp_regs[a] = 8'h00;
        send_bits(17'h00077, 8);
        cs_high(1'b0, 16'h8277, 1'b1);
        chk("midreset_wr_addr", 32'(wr_addr), 32'd0);
        cs_low();
        send_bits(17'h08277, 16);
        cs_high(1'b1, 16'h8277, 1'b1);

        // Minimum host timing, phase of the SPI pins swept against clk.
        half = 3;
        for (int p = 0; p < 4; p++) begin
            ph = 1 + 2 * p + (p / 2);
            for (int a = 0; a < 5; a++) begin
                logic [15:0] f;
                f = {1'b1, 7'(a), 4'(p + 1), 4'(a + 3)};
                cs_low();
                send_bits({1'b0, f}, 16);
                cs_high(1'b1, f, 1'b0);
            end
        end
        tick(8);
        check_regs("min_timing");

        tick(10);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        chk("strobe_count", 32'(nstrobe), 32'(npush));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
